// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - run control, HALT detect/drain and watchdog beside the gate-level CPU
// Holds the CPU in reset, releases it, then snapshots PC/ACC on HALT completion or watchdog expiry.
module cpu_run_monitor #(
  parameter int                DATA_W       = 8,
  parameter int                T_W          = 2,
  parameter logic [DATA_W-1:0] HALT_OP      = 8'hF0,
  parameter int                RST_CYCLES   = 2,
  parameter int                DRAIN_CYCLES = 2,
  parameter int                CYC_W        = 16,
  parameter int                MAX_CYCLES   = 5000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic [DATA_W-1:0] ir,
  input  logic [T_W-1:0]    t,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] acc,
  output logic              cpu_reset,
  output logic              busy,
  output logic              halted,
  output logic              timeout,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [CYC_W-1:0]  instr_count,
  output logic [DATA_W-1:0] final_pc,
  output logic [DATA_W-1:0] final_acc
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HOLD    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_HALTED  = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;

  localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CYC_W-1:0]   WD_LAST    = CYC_W'(MAX_CYCLES - 1);

  logic [2:0]         state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [T_W-1:0]     prev_t;
  logic               halt_detect;
  logic               instr_start;

  assign busy        = (state == S_HOLD) || (state == S_RUN) || (state == S_DRAIN);
  assign halt_detect = (ir == HALT_OP) && (t == '0);
  assign instr_start = (t == '0) && (prev_t != '0);

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == '1) ? v : v + CYC_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cpu_reset   <= 1'b1;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
      final_pc    <= '0;
      final_acc   <= '0;
      hold_cnt    <= '0;
      drain_cnt   <= '0;
      prev_t      <= '0;
    end else begin
      prev_t <= t;
      case (state)
        S_IDLE, S_HALTED, S_TIMEOUT: begin
          if (run) begin
            state       <= S_HOLD;
            hold_cnt    <= '0;
            cycle_count <= '0;
            instr_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          cycle_count <= sat_inc(cycle_count);
          if (instr_start) instr_count <= sat_inc(instr_count);
          // HALT takes precedence over a watchdog expiring on the same edge
          if (halt_detect) begin
            if (DRAIN_CYCLES == 0) begin
              final_pc  <= pc;
              final_acc <= acc;
              halted    <= 1'b1;
              cpu_reset <= 1'b1;
              state     <= S_HALTED;
            end else begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end
          end else if (cycle_count == WD_LAST) begin
            final_pc  <= pc;
            final_acc <= acc;
            timeout   <= 1'b1;
            cpu_reset <= 1'b1;
            state     <= S_TIMEOUT;
          end
        end
        S_DRAIN: begin
          cycle_count <= sat_inc(cycle_count);
          if (drain_cnt == DRAIN_LAST) begin
            final_pc  <= pc;
            final_acc <= acc;
            halted    <= 1'b1;
            cpu_reset <= 1'b1;
            state     <= S_HALTED;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb/tb_cpu_run_monitor.sv - scoreboard bench for cpu_run_monitor
// Three instances: dut0 MAX_CYCLES=20, dut1 MAX_CYCLES=10, dut2 DRAIN_CYCLES=0.
module tb_cpu_run_monitor;

  typedef struct {
    int          dut;
    logic        halted;
    logic        timeout;
    logic [15:0] cyc;
    logic [15:0] ins;
    logic [7:0]  fpc;
    logic [7:0]  facc;
    int          hold;
    int          blen;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n [3];
  logic        run     [3];
  logic [7:0]  ir      [3];
  logic [1:0]  t       [3];
  logic [7:0]  pc      [3];
  logic [7:0]  acc     [3];
  logic        cpu_reset_o [3];
  logic        busy_o      [3];
  logic        halted_o    [3];
  logic        timeout_o   [3];
  logic [15:0] cyc_o       [3];
  logic [15:0] ins_o       [3];
  logic [7:0]  fpc_o       [3];
  logic [7:0]  facc_o      [3];

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic busy_prev [3];
  int   blen [3];
  int   hlen [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cpu_run_monitor #(
      .MAX_CYCLES  ((g == 1) ? 10 : 20),
      .DRAIN_CYCLES((g == 2) ? 0 : 2)
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n[g]),
      .run        (run[g]),
      .ir         (ir[g]),
      .t          (t[g]),
      .pc         (pc[g]),
      .acc        (acc[g]),
      .cpu_reset  (cpu_reset_o[g]),
      .busy       (busy_o[g]),
      .halted     (halted_o[g]),
      .timeout    (timeout_o[g]),
      .cycle_count(cyc_o[g]),
      .instr_count(ins_o[g]),
      .final_pc   (fpc_o[g]),
      .final_acc  (facc_o[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int d, input logic [7:0] i_ir, input logic [1:0] i_t,
                     input logic [7:0] i_pc, input logic [7:0] i_acc);
    ir[d] = i_ir; t[d] = i_t; pc[d] = i_pc; acc[d] = i_acc;
    step();
  endtask

  task automatic ins(input int d, input logic [7:0] op, input logic [7:0] i_pc, input logic [7:0] i_acc);
    for (int k = 0; k < 4; k++) cyc(d, op, 2'(k), i_pc, i_acc);
  endtask

  task automatic start(input int d);
    run[d] = 1'b1; ir[d] = 8'h00; t[d] = 2'd3;
    step();
    run[d] = 1'b0;
  endtask

  task automatic hold(input int d);
    cyc(d, 8'h00, 2'd3, 8'h00, 8'h00);
    cyc(d, 8'h00, 2'd3, 8'h00, 8'h00);
  endtask

  task automatic push(input int d, input logic h, input logic to, input logic [15:0] c,
                      input logic [15:0] n, input logic [7:0] fp, input logic [7:0] fa, input int bl);
    exp_t e;
    e.dut = d; e.halted = h; e.timeout = to; e.cyc = c; e.ins = n;
    e.fpc = fp; e.facc = fa; e.hold = 2; e.blen = bl;
    q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: %0d results still outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic first_hlt(input int d);
    push(d, 1'b1, 1'b0, 16'd3, 16'd1, 8'h12, 8'hA2, 5);
    start(d);
    hold(d);
    cyc(d, 8'hF0, 2'd0, 8'h10, 8'hA0);
    cyc(d, 8'hF0, 2'd1, 8'h11, 8'hA1);
    cyc(d, 8'hF0, 2'd2, 8'h12, 8'hA2);
    wait_done();
  endtask

  // Monitor: a run is complete when busy falls; compare against the oldest expectation
  initial begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      busy_prev[d] = 1'b0; blen[d] = 0; hlen[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (busy_o[d]) begin
          blen[d]++;
          if (cpu_reset_o[d]) hlen[d]++;
        end else if (busy_prev[d]) begin
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_end: dut%0d ended a run, required none", d);
          end else begin
            e = q.pop_front();
            check($sformatf("dut_id(dut%0d)", d), 32'(d), 32'(e.dut));
            check($sformatf("halted(dut%0d)", d), 32'(halted_o[d]), 32'(e.halted));
            check($sformatf("timeout(dut%0d)", d), 32'(timeout_o[d]), 32'(e.timeout));
            check($sformatf("cycle_count(dut%0d)", d), 32'(cyc_o[d]), 32'(e.cyc));
            check($sformatf("instr_count(dut%0d)", d), 32'(ins_o[d]), 32'(e.ins));
            check($sformatf("final_pc(dut%0d)", d), 32'(fpc_o[d]), 32'(e.fpc));
            check($sformatf("final_acc(dut%0d)", d), 32'(facc_o[d]), 32'(e.facc));
            check($sformatf("reset_hold_cycles(dut%0d)", d), 32'(hlen[d]), 32'(e.hold));
            check($sformatf("busy_cycles(dut%0d)", d), 32'(blen[d]), 32'(e.blen));
            check($sformatf("cpu_reset_after(dut%0d)", d), 32'(cpu_reset_o[d]), 32'd1);
          end
          blen[d] = 0;
          hlen[d] = 0;
        end
        busy_prev[d] = busy_o[d];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      reset_n[d] = 1'b0; run[d] = 1'b0; ir[d] = 8'h00;
      t[d] = 2'd3; pc[d] = 8'h00; acc[d] = 8'h00;
    end
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      check("rst_cpu_reset", 32'(cpu_reset_o[d]), 32'd1);
      check("rst_busy", 32'(busy_o[d]), 32'd0);
      check("rst_halted", 32'(halted_o[d]), 32'd0);
      check("rst_timeout", 32'(timeout_o[d]), 32'd0);
      check("rst_cycle_count", 32'(cyc_o[d]), 32'd0);
      check("rst_instr_count", 32'(ins_o[d]), 32'd0);
      check("rst_final_pc", 32'(fpc_o[d]), 32'd0);
      check("rst_final_acc", 32'(facc_o[d]), 32'd0);
      reset_n[d] = 1'b1;
    end
    step();

    first_hlt(0);

    // Restart from HALTED, then a four-instruction program ending in HLT
    push(0, 1'b1, 1'b0, 16'd19, 16'd5, 8'h04, 8'h08, 21);
    start(0);
    check("restart_halted_cleared", 32'(halted_o[0]), 32'd0);
    check("restart_cycle_cleared", 32'(cyc_o[0]), 32'd0);
    check("restart_instr_cleared", 32'(ins_o[0]), 32'd0);
    check("restart_busy", 32'(busy_o[0]), 32'd1);
    check("restart_cpu_reset", 32'(cpu_reset_o[0]), 32'd1);
    hold(0);
    ins(0, 8'h11, 8'h00, 8'h00);
    ins(0, 8'h22, 8'h01, 8'h05);
    ins(0, 8'h33, 8'h02, 8'h06);
    ins(0, 8'h44, 8'h03, 8'h07);
    cyc(0, 8'hF0, 2'd0, 8'h04, 8'h08);
    cyc(0, 8'hF0, 2'd1, 8'h04, 8'h08);
    cyc(0, 8'hF0, 2'd2, 8'h04, 8'h08);
    wait_done();

    // Non-halting loop: watchdog after exactly 20 RUN cycles
    push(0, 1'b0, 1'b1, 16'd20, 16'd5, 8'h04, 8'h34, 22);
    start(0);
    hold(0);
    for (int i = 0; i < 5; i++) ins(0, 8'h55, 8'(i), 8'(8'h30 + i));
    wait_done();

    // Reset asserted mid-DRAIN: everything back to reset values
    push(0, 1'b0, 1'b0, 16'd0, 16'd0, 8'h00, 8'h00, 5);
    start(0);
    hold(0);
    cyc(0, 8'hF0, 2'd0, 8'h20, 8'h40);
    cyc(0, 8'hF0, 2'd1, 8'h21, 8'h41);
    reset_n[0] = 1'b0;
    cyc(0, 8'hF0, 2'd2, 8'h22, 8'h42);
    reset_n[0] = 1'b1;
    wait_done();
    first_hlt(0);

    // HALT detect on the same edge the watchdog would fire
    push(1, 1'b1, 1'b0, 16'd12, 16'd3, 8'h0A, 8'h1A, 14);
    start(1);
    hold(1);
    ins(1, 8'h55, 8'h00, 8'h00);
    ins(1, 8'h55, 8'h01, 8'h01);
    cyc(1, 8'h55, 2'd1, 8'h02, 8'h02);
    cyc(1, 8'hF0, 2'd0, 8'h09, 8'h19);
    cyc(1, 8'hF0, 2'd1, 8'h09, 8'h19);
    cyc(1, 8'hF0, 2'd2, 8'h0A, 8'h1A);
    wait_done();

    // No drain: halted on the detect edge itself
    push(2, 1'b1, 1'b0, 16'd5, 16'd2, 8'h01, 8'h02, 7);
    start(2);
    hold(2);
    ins(2, 8'h11, 8'h00, 8'h01);
    cyc(2, 8'hF0, 2'd0, 8'h01, 8'h02);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
